ray_dispatch_scheduler: RTL
===========================

# ray_dispatch_scheduler

Dispatches pixel threads from the thread generator to a pool of `NUM_CORES` ray cores. It accepts one pixel coordinate per handshake and picks an idle core in round-robin order. It starts that core with a one-cycle pulse and tracks which cores are busy until they report done. It also sequences a frame (start, run, drain, done), so the top level sees one frame-complete pulse after the last pixel's core finishes.

## Interface
- `NUM_CORES`, 4: number of ray cores; 2..16.
- `COORD_W`, 10: pixel coordinate width.
- `CNT_W`, 20: width of dispatched-pixel counter.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low (0 = reset).
- `frame_start` in 1: one-cycle pulse; starts a frame from IDLE.
- `pixel_x` in COORD_W: coordinate from the thread generator.
- `pixel_y` in COORD_W: coordinate from the thread generator.
- `pixel_valid` in 1: coordinate valid.
- `pixel_last` in 1: qualifies `pixel_valid`; marks the final pixel of the frame.
- `gen_ready` out 1: scheduler can accept a pixel; drives the generator's ray-core-free input.
- `core_free` in NUM_CORES: core k is idle and able to start.
- `core_done` in NUM_CORES: one-cycle pulse; core k finished its pixel.
- `core_start` out NUM_CORES: one-hot start pulse.
- `core_pixel_x` out COORD_W: coordinate for the started core; broadcast to all cores.
- `core_pixel_y` out COORD_W: coordinate for the started core; broadcast to all cores.
- `busy` out NUM_CORES: cores currently owned by the scheduler.
- `frame_done` out 1: one-cycle pulse at frame completion.
- `dispatched_count` out CNT_W: pixels dispatched in the current frame.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **Availability:** `avail[k] = core_free[k] & ~busy[k]`.
- **IDLE:**
  - `gen_ready`=0.
  - `frame_start`=1 -> RUN. At the same time, clear `dispatched_count` and set the round-robin pointer to 0.
- **RUN:**
  - `gen_ready` is combinational: `gen_ready = |avail`.
  - Accept occurs when `pixel_valid & gen_ready`.
  - Grant goes to the first `avail` index at or after the pointer, wrapping from NUM_CORES-1 to 0.
  - On the accept edge:
    - register `core_start` one-hot to the granted core, and register `core_pixel_x/y`;
    - set `busy[g]`;
    - set pointer = (g+1) mod NUM_CORES;
    - increment `dispatched_count`.
  - Accept with `pixel_last`=1 -> DRAIN.
- **DRAIN:**
  - `gen_ready`=0; `pixel_valid` is ignored.
  - When `busy`==0 and `core_start`==0 -> DONE.
- **DONE:** `frame_done`=1 for exactly one cycle -> IDLE.
- **Completion:** `core_done[k]` clears `busy[k]` on the next edge in any state. `core_done` on a non-busy core is ignored.
- **Same-cycle done and dispatch:** a done for core k and a dispatch to a different core j in the same cycle are both applied. A dispatch to k itself cannot happen that cycle, because `busy[k]`=1 masks it.
- **Ignored inputs:**
  - `frame_start` outside IDLE.
  - `core_free` changes while a core is busy; `busy` alone decides ownership.
- **Counter saturation:** `dispatched_count` saturates at 2^CNT_W-1.
- **Pointer:** holds when no accept occurs.

## Timing
- **Reset values:**
  - state IDLE, pointer 0;
  - `gen_ready`=0, `core_start`=0, `core_pixel_x/y`=0, `busy`=0, `frame_done`=0, `dispatched_count`=0.
- **Reset mid-frame:** asserting `rst` in any state returns to IDLE and clears all of the above immediately, without waiting for a clock. Cores in flight are abandoned; their later `core_done` is ignored.
- **Dispatch latency:** accept at edge N -> `core_start` high during cycle N+1 only. `core_pixel_x/y` stay stable until the next accept.
- **Throughput:** one pixel per cycle while `avail` is non-zero.
- **Frame end:** the last `core_done` is sampled at edge M -> DRAIN->DONE at M+1 -> `frame_done` high in cycle M+1 -> IDLE at M+2.
- **Back-to-back frames:** earliest new `frame_start` accepted is in the cycle after `frame_done`.

## Test plan
- **Reset values:** hold `rst`=0, pulse `clk` -> all outputs 0; `gen_ready`=0 even with `pixel_valid`=1.
- **Round-robin dispatch:** NUM_CORES=4, all `core_free`=1; frame_start, then 4 pixels (0,0),(1,0),(2,0),(3,0) back-to-back.
  - `core_start` = 0001, 0010, 0100, 1000 on consecutive cycles, each one cycle after its accept.
  - `busy`=1111, `gen_ready`=0, `dispatched_count`=4.
- **Backpressure and done:** with all cores busy, `gen_ready`=0. Pulse `core_done[2]`; then `gen_ready`=1 next cycle, and the next pixel (5,7) goes to core 2 with `core_pixel_x`=5 and `core_pixel_y`=7.
- **Simultaneous events:**
  - `core_done[0]` in the same cycle as a dispatch to core 1 -> `busy[0]` clears and `busy[1]` sets on the same edge.
  - `core_done[3]` while `busy[3]`=0 -> no change.
- **Frame end:** send 6 pixels, the last with `pixel_last`=1, then release cores one by one.
  - `frame_done` pulses once, exactly one cycle after the final `busy` bit clears.
  - `dispatched_count`=6.
  - State returns to IDLE; a `frame_start` issued during DRAIN is ignored.
- **Reset mid-frame:** assert `rst`=0 with `busy`=0110 in RUN -> all outputs 0 immediately; a later `core_done[1]` does not set `frame_done`.

Source files
------------

// File: rtl/ray_dispatch_scheduler_if.sv
// Pixel-dispatch bundle between the generator, the scheduler and the cores.
// slave: scheduler side; master: generator/core side.
interface ray_dispatch_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int COORD_W   = 10,
  parameter int CNT_W     = 20
);
  logic                 frame_start;
  logic [COORD_W-1:0]   pixel_x;
  logic [COORD_W-1:0]   pixel_y;
  logic                 pixel_valid;
  logic                 pixel_last;
  logic                 gen_ready;
  logic [NUM_CORES-1:0] core_free;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_start;
  logic [COORD_W-1:0]   core_pixel_x;
  logic [COORD_W-1:0]   core_pixel_y;
  logic [NUM_CORES-1:0] busy;
  logic                 frame_done;
  logic [CNT_W-1:0]     dispatched_count;

  modport slave (
    input  frame_start, pixel_x, pixel_y,
    input  pixel_valid, pixel_last,
    input  core_free, core_done,
    output gen_ready, core_start,
    output core_pixel_x, core_pixel_y,
    output busy, frame_done, dispatched_count
  );

  modport master (
    output frame_start, pixel_x, pixel_y,
    output pixel_valid, pixel_last,
    output core_free, core_done,
    input  gen_ready, core_start,
    input  core_pixel_x, core_pixel_y,
    input  busy, frame_done, dispatched_count
  );
endinterface

// File: rtl/ray_dispatch_scheduler.sv
// Round-robin pixel dispatcher to NUM_CORES ray cores with frame sequencing.
// Ports: clk, rst (async, active-low), bus (slave modport, all handshakes).
module ray_dispatch_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int COORD_W   = 10,
  parameter int CNT_W     = 20
) (
  input logic                     clk,
  input logic                     rst,
  ray_dispatch_scheduler_if.slave bus
);
  localparam int PW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_CORES-1:0] avail, gnt_oh;
  logic [PW-1:0]        gnt;
  logic                 found, ready, accept;

  assign avail = bus.core_free & ~busy_q;

  // first available core at or after the pointer, wrapping
  always_comb begin : arb
    int            j;
    logic [PW-1:0] jj;
    j     = 0;
    jj    = '0;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      jj = PW'(j);
      if (!found && avail[jj]) begin
        found = 1'b1;
        gnt   = jj;
      end
    end
  end

  assign gnt_oh = NUM_CORES'(1) << gnt;
  assign ready  = (state_q == RUN) && found;
  assign accept = ready && bus.pixel_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    start_d = '0;
    busy_d  = busy_q & ~bus.core_done;
    if (accept) begin
      busy_d  = busy_d | gnt_oh;
      start_d = gnt_oh;
      x_d     = bus.pixel_x;
      y_d     = bus.pixel_y;
      ptr_d   = (gnt == PW'(NUM_CORES - 1))
              ? '0 : gnt + PW'(1);
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d = RUN;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      RUN: begin
        if (accept && bus.pixel_last) state_d = DRAIN;
      end
      DRAIN: begin
        // wait for the last start pulse to land as well
        if (busy_q == '0 && start_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= '0;
      start_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gen_ready        = ready;
  assign bus.core_start       = start_q;
  assign bus.core_pixel_x     = x_q;
  assign bus.core_pixel_y     = y_q;
  assign bus.busy             = busy_q;
  assign bus.frame_done       = (state_q == DONE);
  assign bus.dispatched_count = cnt_q;
endmodule
